// File: rtl/eth_tx_frame_shaper.sv
// Ethernet TX frame shaper: zero-latency pass-through that pads short frames with zero words and
// then holds off upstream for a fixed inter-frame gap. Define ETH_TX_FRAME_SHAPER_STATS_EN for frame counters.
module eth_tx_frame_shaper #(
    parameter int width_p           = 8,
    parameter int min_frame_words_p = 16,
    parameter int ifg_cycles_p      = 12
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic [width_p-1:0] data_i,
    input  logic               v_i,
    input  logic               last_i,
    output logic               ready_and_o,
    output logic [width_p-1:0] data_o,
    output logic               v_o,
    output logic               last_o,
    input  logic               ready_and_i
`ifdef ETH_TX_FRAME_SHAPER_STATS_EN
    ,
    output logic [31:0]        frames_o,
    output logic [31:0]        padded_frames_o
`endif
);

    typedef enum logic [1:0] {
        ST_DATA,
        ST_PAD,
        ST_GAP
    } state_e;

    localparam int cnt_w_lp  = $clog2(min_frame_words_p + 1);
    localparam int gcnt_w_lp = (ifg_cycles_p > 0) ? $clog2(ifg_cycles_p + 1) : 1;

    localparam logic [cnt_w_lp:0]    min_lp      = (cnt_w_lp + 1)'(min_frame_words_p);
    localparam logic [cnt_w_lp:0]    cnt_one_lp  = (cnt_w_lp + 1)'(1);
    localparam logic [cnt_w_lp-1:0]  cnt_max_lp  = cnt_w_lp'(min_frame_words_p);
    localparam logic [cnt_w_lp-1:0]  pad_last_lp = cnt_w_lp'(min_frame_words_p - 1);
    localparam logic [gcnt_w_lp-1:0] gap_last_lp = gcnt_w_lp'((ifg_cycles_p > 0) ? ifg_cycles_p - 1 : 0);
    localparam logic [gcnt_w_lp-1:0] gcnt_one_lp = gcnt_w_lp'(1);
    localparam state_e               after_frame_lp = (ifg_cycles_p > 0) ? ST_GAP : ST_DATA;

    state_e                 state_reg;
    logic [cnt_w_lp-1:0]    cnt_reg;
    logic [gcnt_w_lp-1:0]   gcnt_reg;

    logic [cnt_w_lp:0]      cnt_inc;
    logic [cnt_w_lp-1:0]    cnt_sat;
    logic                   reach_min;
    logic                   out_fire;

    // One extra bit so cnt+1 never wraps before the minimum-length comparison.
    assign cnt_inc   = {1'b0, cnt_reg} + cnt_one_lp;
    assign reach_min = (cnt_inc >= min_lp);
    assign cnt_sat   = (cnt_reg == cnt_max_lp) ? cnt_reg : cnt_inc[cnt_w_lp-1:0];
    assign out_fire  = v_o & ready_and_i;

    // Outputs are forced idle while reset is asserted, independent of the pass-through path.
    always_comb begin
        data_o      = '0;
        v_o         = 1'b0;
        last_o      = 1'b0;
        ready_and_o = 1'b0;
        if (reset_n_i) begin
            case (state_reg)
                ST_DATA: begin
                    data_o      = data_i;
                    v_o         = v_i;
                    ready_and_o = ready_and_i;
                    last_o      = last_i & reach_min;
                end
                ST_PAD: begin
                    v_o    = 1'b1;
                    last_o = (cnt_reg == pad_last_lp);
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_reg <= ST_DATA;
            cnt_reg   <= '0;
            gcnt_reg  <= '0;
        end else begin
            case (state_reg)
                ST_DATA: begin
                    if (out_fire) begin
                        if (!last_i) begin
                            cnt_reg <= cnt_sat;
                        end else if (reach_min) begin
                            cnt_reg   <= '0;
                            state_reg <= after_frame_lp;
                        end else begin
                            cnt_reg   <= cnt_inc[cnt_w_lp-1:0];
                            state_reg <= ST_PAD;
                        end
                    end
                end
                ST_PAD: begin
                    if (out_fire) begin
                        if (cnt_reg == pad_last_lp) begin
                            cnt_reg   <= '0;
                            state_reg <= after_frame_lp;
                        end else begin
                            cnt_reg <= cnt_inc[cnt_w_lp-1:0];
                        end
                    end
                end
                ST_GAP: begin
                    // The gap runs on cycles alone; downstream ready has no say here.
                    if (gcnt_reg == gap_last_lp) begin
                        gcnt_reg  <= '0;
                        state_reg <= ST_DATA;
                    end else begin
                        gcnt_reg <= gcnt_reg + gcnt_one_lp;
                    end
                end
                default: state_reg <= ST_DATA;
            endcase
        end
    end

`ifdef ETH_TX_FRAME_SHAPER_STATS_EN
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            frames_o        <= '0;
            padded_frames_o <= '0;
        end else begin
            if (out_fire && last_o) begin
                frames_o <= frames_o + 32'd1;
            end
            if ((state_reg == ST_DATA) && out_fire && last_i && !reach_min) begin
                padded_frames_o <= padded_frames_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_eth_tx_frame_shaper.sv
// Bench for eth_tx_frame_shaper: directed scenarios with literal expectations, then randomized frames
// checked every cycle against a frame-level model (output stream = words + zero padding, then a fixed gap).
module tb_eth_tx_frame_shaper;

    localparam int MIN = 4;
    localparam int IFG = 3;

    logic       clk_i = 1'b0;
    logic       reset_n_i;
    logic [7:0] data_i;
    logic       v_i, last_i, ready_and_o;
    logic [7:0] data_o;
    logic       v_o, last_o, ready_and_i;

    logic [7:0] d2_data_i, d2_data_o;
    logic       d2_v_i, d2_last_i, d2_ready_and_o, d2_v_o, d2_last_o, d2_ready_and_i;

`ifdef ETH_TX_FRAME_SHAPER_STATS_EN
    logic [31:0] frames_o, padded_frames_o, d2_frames_o, d2_padded_frames_o;
`endif

    always #5 clk_i = ~clk_i;

    eth_tx_frame_shaper #(.width_p(8), .min_frame_words_p(MIN), .ifg_cycles_p(IFG)) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .data_i(data_i), .v_i(v_i), .last_i(last_i), .ready_and_o(ready_and_o),
        .data_o(data_o), .v_o(v_o), .last_o(last_o), .ready_and_i(ready_and_i)
`ifdef ETH_TX_FRAME_SHAPER_STATS_EN
        , .frames_o(frames_o), .padded_frames_o(padded_frames_o)
`endif
    );

    eth_tx_frame_shaper #(.width_p(8), .min_frame_words_p(1), .ifg_cycles_p(0)) dut2 (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .data_i(d2_data_i), .v_i(d2_v_i), .last_i(d2_last_i), .ready_and_o(d2_ready_and_o),
        .data_o(d2_data_o), .v_o(d2_v_o), .last_o(d2_last_o), .ready_and_i(d2_ready_and_i)
`ifdef ETH_TX_FRAME_SHAPER_STATS_EN
        , .frames_o(d2_frames_o), .padded_frames_o(d2_padded_frames_o)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s at t=%0t", name, $time);
    endtask

    // Frame-level reference: expected output stream and per-cycle phase bookkeeping.
    logic [8:0] exp_q[$];
    logic [8:0] src_q[$];
    int  n_out = 0, pad_left = 0, gap_left = 0;
    bit  prev_stall = 0;
    logic [9:0] prev_out;
    bit  in_fire_s = 0;
    bit  rand_mode = 0;
    int  frames_left = 0;

    task automatic expect_frame(input logic [7:0] words[$]);
        int total;
        total = (words.size() > MIN) ? words.size() : MIN;
        for (int i = 0; i < total; i++)
            exp_q.push_back({(i == total - 1), (i < words.size()) ? words[i] : 8'h00});
    endtask

    always @(negedge clk_i) begin
        logic [10:0] act, e;
        logic [8:0]  w;
        act = {v_o, ready_and_o, last_o, data_o};
        if (!reset_n_i) begin
            check("reset_outputs", 32'(act), 32'd0);
            n_out = 0; pad_left = 0; gap_left = 0;
            exp_q.delete();
            prev_stall = 0;
            in_fire_s = 0;
        end else begin
            if (gap_left > 0) begin
                e = '0;
                gap_left--;
            end else if (pad_left > 0) begin
                e = {1'b1, 1'b0, (pad_left == 1), 8'h00};
                if (ready_and_i) begin
                    pad_left--;
                    if (pad_left == 0) gap_left = IFG;
                end
            end else begin
                e = {v_i, ready_and_i, last_i && (n_out + 1 >= MIN), data_i};
                if (v_i && ready_and_i) begin
                    n_out++;
                    if (last_i) begin
                        if (n_out < MIN) pad_left = MIN - n_out;
                        else gap_left = IFG;
                        n_out = 0;
                    end
                end
            end
            check("cycle_outputs", 32'(act), 32'(e));
            if (prev_stall) check("stall_hold", 32'({v_o, last_o, data_o}), 32'(prev_out));
            prev_stall = v_o && !ready_and_i;
            prev_out   = {v_o, last_o, data_o};
            if (v_o && ready_and_i) begin
                if (exp_q.size() == 0) fail_now("stream_unexpected_word");
                else begin
                    w = exp_q.pop_front();
                    check("stream_word", 32'({last_o, data_o}), 32'(w));
                end
            end
            in_fire_s = v_i && ready_and_o;
        end
    end

    task automatic gen_frame();
        int len;
        logic [7:0] q[$];
        len = ($urandom_range(0, 9) == 0) ? $urandom_range(8, 20) : $urandom_range(1, 7);
        for (int i = 0; i < len; i++) begin
            q.push_back(8'($urandom));
            src_q.push_back({(i == len - 1), q[i]});
        end
        expect_frame(q);
        frames_left--;
    endtask

    // Random upstream/downstream driver; upstream holds its word until accepted.
    always @(posedge clk_i) begin
        logic [8:0] w;
        #1;
        if (rand_mode) begin
            ready_and_i = ($urandom_range(0, 3) != 0);
            if (!v_i || in_fire_s) begin
                if (src_q.size() == 0 && frames_left > 0) gen_frame();
                if (src_q.size() != 0 && $urandom_range(0, 3) != 0) begin
                    w = src_q.pop_front();
                    v_i = 1'b1; last_i = w[8]; data_i = w[7:0];
                end else begin
                    v_i = 1'b0; last_i = 1'($urandom); data_i = 8'($urandom);
                end
            end
        end
    end

    task automatic send_word(input logic [7:0] d, input bit l, output int waited);
        @(posedge clk_i); #1;
        v_i = 1'b1; data_i = d; last_i = l; waited = 0;
        @(negedge clk_i);
        while (!ready_and_o && waited < 50) begin
            waited++;
            @(negedge clk_i);
        end
        if (!ready_and_o) fail_now("send_timeout");
    endtask

    task automatic go_idle();
        @(posedge clk_i); #1;
        v_i = 1'b0; last_i = 1'b0; data_i = 8'h00;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog_timeout at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] q[$];
        logic [8:0] got[$];
        logic [6:0] pat;
        int w, idx, lasts, budget;
        bit fired;

        reset_n_i = 1'b0; v_i = 0; last_i = 0; data_i = 0; ready_and_i = 1'b1;
        d2_v_i = 0; d2_last_i = 0; d2_data_i = 0; d2_ready_and_i = 1'b1;
        repeat (3) @(negedge clk_i);
        @(posedge clk_i); #2;
        reset_n_i = 1'b1;
        @(negedge clk_i);
        check("reset_release", 32'({v_o, ready_and_o, last_o, data_o}), 32'({1'b0, 1'b1, 1'b0, 8'h00}));

        // Short frame gets padded, then the gap.
        q.delete(); q.push_back(8'hA1); q.push_back(8'hA2);
        expect_frame(q);
        send_word(8'hA1, 0, w);
        check("t2_a1", 32'({v_o, ready_and_o, last_o, data_o}), 32'({1'b1, 1'b1, 1'b0, 8'hA1}));
        send_word(8'hA2, 1, w);
        check("t2_a2_no_last", 32'({v_o, ready_and_o, last_o, data_o}), 32'({1'b1, 1'b1, 1'b0, 8'hA2}));
        go_idle();
        @(negedge clk_i);
        check("t2_pad1", 32'({v_o, ready_and_o, last_o, data_o}), 32'({1'b1, 1'b0, 1'b0, 8'h00}));
        @(negedge clk_i);
        check("t2_pad2_last", 32'({v_o, ready_and_o, last_o, data_o}), 32'({1'b1, 1'b0, 1'b1, 8'h00}));
        repeat (3) begin
            @(negedge clk_i);
            check("t2_gap", 32'({v_o, ready_and_o, last_o, data_o}), 32'd0);
        end
        @(negedge clk_i);
        check("t2_gap_end", 32'(ready_and_o), 32'd1);
`ifdef ETH_TX_FRAME_SHAPER_STATS_EN
        check("t2_frames", frames_o, 32'd1);
        check("t2_padded", padded_frames_o, 32'd1);
`endif

        // Long frame passes unchanged; next word waits out exactly the gap.
        q.delete();
        for (int i = 0; i < 6; i++) q.push_back(8'(8'h11 + i));
        expect_frame(q);
        for (int i = 0; i < 6; i++) begin
            send_word(8'(8'h11 + i), (i == 5), w);
            check("t1_latency", 32'(w), 32'd0);
            check("t1_word", 32'({v_o, last_o, data_o}), 32'({1'b1, (i == 5), 8'(8'h11 + i)}));
        end
        q.delete();
        for (int i = 0; i < 4; i++) q.push_back(8'(8'h17 + i));
        expect_frame(q);
        send_word(8'h17, 0, w);
        check("t1_gap_wait", 32'(w), 32'd3);
        for (int i = 1; i < 4; i++) send_word(8'(8'h17 + i), (i == 3), w);
        go_idle();
        repeat (5) @(negedge clk_i);

        // Downstream stalls inside a frame.
        q.delete();
        for (int i = 0; i < 4; i++) q.push_back(8'(8'hB1 + i));
        expect_frame(q);
        pat = 7'b1011001;  // bit k = ready on cycle k: 1,0,0,1,1,0,1
        idx = 0; fired = 0; got.delete();
        for (int k = 0; k < 7; k++) begin
            @(posedge clk_i); #1;
            ready_and_i = pat[k];
            if (!v_i || fired) begin
                if (idx < 4) begin
                    v_i = 1'b1; data_i = q[idx]; last_i = (idx == 3); idx++;
                end else begin
                    v_i = 1'b0; data_i = 8'h00; last_i = 1'b0;
                end
            end
            @(negedge clk_i);
            if (v_o && ready_and_i) got.push_back({last_o, data_o});
            fired = v_i && ready_and_o;
        end
        check("t3_count", 32'(got.size()), 32'd4);
        lasts = 0;
        for (int i = 0; i < got.size() && i < 4; i++) begin
            check("t3_word", 32'(got[i]), 32'({(i == 3), 8'(8'hB1 + i)}));
            lasts += int'(got[i][8]);
        end
        check("t3_one_last", 32'(lasts), 32'd1);
        go_idle();
        ready_and_i = 1'b1;
        repeat (5) @(negedge clk_i);

        // Stall during padding.
        q.delete(); q.push_back(8'hC1);
        expect_frame(q);
        send_word(8'hC1, 1, w);
        go_idle();
        ready_and_i = 1'b0;
        repeat (5) begin
            @(negedge clk_i);
            check("t4_pad_stall", 32'({v_o, ready_and_o, last_o, data_o}), 32'({1'b1, 1'b0, 1'b0, 8'h00}));
        end
        @(posedge clk_i); #1;
        ready_and_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            check("t4_pad_word", 32'({v_o, ready_and_o, last_o, data_o}), 32'({1'b1, 1'b0, (k == 2), 8'h00}));
        end
        @(negedge clk_i);
        check("t4_after_pad", 32'({v_o, ready_and_o}), 32'd0);
        repeat (4) @(negedge clk_i);

        // Asynchronous reset mid-frame.
        q.delete();
        for (int i = 0; i < 5; i++) q.push_back(8'(8'hD1 + i));
        expect_frame(q);
        send_word(8'hD1, 0, w);
        @(posedge clk_i); #1;
        v_i = 1'b1; data_i = 8'hD2; last_i = 1'b0;
        #2 reset_n_i = 1'b0;
        #1 check("t5_async_reset", 32'({v_o, ready_and_o, last_o, data_o}), 32'd0);
        v_i = 1'b0; data_i = 8'h00;
        @(posedge clk_i); #3;
        reset_n_i = 1'b1;
        q.delete();
        for (int i = 0; i < 4; i++) q.push_back(8'(8'hE1 + i));
        expect_frame(q);
        for (int i = 0; i < 4; i++) begin
            send_word(8'(8'hE1 + i), (i == 3), w);
            check("t5_word", 32'({w[7:0], last_o, data_o}), 32'({8'd0, (i == 3), 8'(8'hE1 + i)}));
        end
        go_idle();
        @(negedge clk_i);
        check("t5_no_pad", 32'({v_o, ready_and_o}), 32'd0);
        repeat (4) @(negedge clk_i);

        // min=1, no gap: back-to-back single-word frames on the second instance.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_i); #1;
            d2_v_i = 1'b1; d2_data_i = 8'(i + 1); d2_last_i = 1'b1;
            @(negedge clk_i);
            check("t6_word", 32'({d2_v_o, d2_ready_and_o, d2_last_o, d2_data_o}), 32'({1'b1, 1'b1, 1'b1, 8'(i + 1)}));
        end
        @(posedge clk_i); #1;
        d2_v_i = 1'b0; d2_last_i = 1'b0; d2_data_i = 8'h00;
        @(negedge clk_i);
        check("t6_ready_held", 32'({d2_v_o, d2_ready_and_o}), 32'({1'b0, 1'b1}));

        // Randomized frames and stalls.
        frames_left = 250;
        rand_mode = 1;
        budget = 0;
        while ((frames_left > 0 || src_q.size() != 0 || exp_q.size() != 0) && budget < 40000) begin
            @(negedge clk_i);
            budget++;
        end
        if (budget >= 40000) fail_now("random_drain_timeout");
        rand_mode = 0;
        go_idle();
        repeat (5) @(negedge clk_i);
        check("random_all_consumed", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
